// File: rtl/cpu_types_pkg.sv
// Common CPU word types, constants and small address helpers.
// The fetch stage and its pipeline latch import these.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // All-zero word decodes as sll $0,$0,0, so a bubble is a harmless nop.
   localparam word_t NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FU_RUN    = 1'b0,
      FU_HALTED = 1'b1
   } fetch_state_t;

   function automatic word_t branch_target(input word_t pc4, input logic [15:0] imm);
      return pc4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic word_t jump_target(input word_t pc4, input word_t instr);
      return {pc4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Shared select encodings for the datapath multiplexers.
// The control unit drives these; the fetch stage consumes the next-PC select.
package data_path_muxs_pkg;

   typedef enum logic [1:0] {
      SEL_PC4    = 2'd0,
      SEL_BRANCH = 2'd1,
      SEL_JUMP   = 2'd2,
      SEL_JR     = 2'd3
   } pc_mux_input_selection;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch-stage signals for connecting the stage to the rest of the CPU.
// The fu modport is the fetch unit's own view.
interface fetch_unit_if;
   import data_path_muxs_pkg::*;

   logic                  ihit;
   logic [31:0]           imemload;
   logic                  iREN;
   logic [31:0]           imemaddr;
   logic                  stall;
   pc_mux_input_selection PCSrc;
   logic                  branch_taken;
   logic [15:0]           imm16;
   logic [31:0]           jr_addr;
   logic                  halt;
   logic [31:0]           instr_IF_ID;
   logic [31:0]           pc4_IF_ID;
   logic                  valid_IF_ID;
   logic [5:0]            opcode_IF_ID;
   logic [5:0]            func_IF_ID;

   modport fu (
      input  ihit, imemload, stall, PCSrc, branch_taken, imm16, jr_addr, halt,
      output iREN, imemaddr, instr_IF_ID, pc4_IF_ID, valid_IF_ID, opcode_IF_ID, func_IF_ID
   );

endinterface

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: instruction word, PC+4 and a valid flag.
// bubble wins over load; with neither asserted the contents hold.
module if_id_latch
   import cpu_types_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] new_instr,
   input  logic [31:0] new_pc4,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   word_t instr_reg;
   word_t pc4_reg;
   logic  valid_reg;

   always_ff @(posedge clk) begin
      if (srst || bubble) begin
         instr_reg <= NOP_INSTR;
         pc4_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (load) begin
         instr_reg <= new_instr;
         pc4_reg   <= new_pc4;
         valid_reg <= 1'b1;
      end
   end

   assign instr = instr_reg;
   assign pc4   = pc4_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, I-cache request, run/halt FSM and
// next-PC steering from the decode stage. Redirects squash exactly one fetch.
module fetch_unit
   import data_path_muxs_pkg::*;
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ihit,
   input  logic [31:0]           imemload,
   output logic                  iREN,
   output logic [31:0]           imemaddr,
   input  logic                  stall,
   input  pc_mux_input_selection PCSrc,
   input  logic                  branch_taken,
   input  logic [15:0]           imm16,
   input  logic [31:0]           jr_addr,
   input  logic                  halt,
   output logic [31:0]           instr_IF_ID,
   output logic [31:0]           pc4_IF_ID,
   output logic                  valid_IF_ID,
   output logic [5:0]            opcode_IF_ID,
   output logic [5:0]            func_IF_ID
);

   fetch_state_t state_reg, state_next;
   word_t        pc_reg, pc_next;
   word_t        pc_plus4;
   word_t        target;
   logic         redirect;
   logic         halt_valid;
   logic         latch_load;
   logic         latch_bubble;

   assign pc_plus4   = pc_reg + 32'd4;
   assign halt_valid = valid_IF_ID && halt;

   // Decode-stage controls only count when IF/ID holds a real instruction.
   always_comb begin
      redirect = 1'b0;
      target   = pc_plus4;
      if (valid_IF_ID) begin
         unique case (PCSrc)
            SEL_BRANCH: begin
               redirect = branch_taken;
               target   = branch_target(pc4_IF_ID, imm16);
            end
            SEL_JUMP: begin
               redirect = 1'b1;
               target   = jump_target(pc4_IF_ID, instr_IF_ID);
            end
            SEL_JR: begin
               redirect = 1'b1;
               target   = jr_addr;
            end
            default: begin
               redirect = 1'b0;
               target   = pc_plus4;
            end
         endcase
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      latch_load   = 1'b0;
      latch_bubble = 1'b0;
      if (!stall) begin
         if (halt_valid) begin
            state_next   = FU_HALTED;
            latch_bubble = 1'b1;
         end else if (redirect) begin
            pc_next      = target;
            latch_bubble = 1'b1;
         end else if (state_reg == FU_RUN && ihit) begin
            pc_next    = pc_plus4;
            latch_load = 1'b1;
         end else begin
            latch_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= FU_RUN;
         pc_reg    <= PC_INIT;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   if_id_latch u_if_id_latch (
      .clk       (CLK),
      .srst      (RST),
      .load      (latch_load),
      .bubble    (latch_bubble),
      .new_instr (imemload),
      .new_pc4   (pc_plus4),
      .instr     (instr_IF_ID),
      .pc4       (pc4_IF_ID),
      .valid     (valid_IF_ID)
   );

   assign iREN         = (state_reg == FU_RUN);
   assign imemaddr     = pc_reg;
   assign opcode_IF_ID = instr_IF_ID[31:26];
   assign func_IF_ID   = instr_IF_ID[5:0];

endmodule
